// File: rtl/tiger_avalon_pkg.sv
// Shared constants and helpers for the tiger Avalon-MM register slave.
package tiger_avalon_pkg;

    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;
    localparam logic [AV_DATA_W-1:0] AV_ERR_DATA = 32'hDEAD_BEEF;

    localparam int AV_LAT_MIN  = 1;
    localparam int AV_LAT_MAX  = 4;
    localparam int AV_PEND_MIN = 1;
    localparam int AV_PEND_MAX = 4;
    localparam int AV_PEND_W   = 3;

    function automatic logic [AV_DATA_W-1:0] be_merge(
        input logic [AV_DATA_W-1:0] old_word,
        input logic [AV_DATA_W-1:0] new_word,
        input logic [AV_BE_W-1:0]   be
    );
        logic [AV_DATA_W-1:0] r;
        r = old_word;
        for (int b = 0; b < AV_BE_W; b++)
            if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/tiger_avalon_read_pipe.sv
// Fixed-latency read return path: valid+data shift register feeding the
// registered readdata/readdatavalid outputs.
module tiger_avalon_read_pipe
    import tiger_avalon_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [AV_DATA_W-1:0] in_data,
    output logic                 ret_next,
    output logic [AV_DATA_W-1:0] avs_readdata,
    output logic                 avs_readdatavalid
);

    logic [AV_DATA_W-1:0] ret_data;

    // ret_next marks the entry that becomes readdatavalid on the next edge;
    // the slave retires its pending count on it so the slot frees one cycle early.
    if (READ_LATENCY == 1) begin : g_lat1
        assign ret_next = in_valid;
        assign ret_data = in_data;
    end else begin : g_latn
        logic [READ_LATENCY-2:0]                vld_pipe;
        logic [READ_LATENCY-2:0][AV_DATA_W-1:0] dat_pipe;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else begin
                for (int k = READ_LATENCY - 2; k > 0; k--) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    dat_pipe[k] <= dat_pipe[k-1];
                end
                vld_pipe[0] <= in_valid;
                dat_pipe[0] <= in_data;
            end
        end

        assign ret_next = vld_pipe[READ_LATENCY-2];
        assign ret_data = dat_pipe[READ_LATENCY-2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            avs_readdatavalid <= ret_next;
            if (ret_next) avs_readdata <= ret_data;
        end
    end

endmodule

// File: rtl/tiger_avalon_slave.sv
// Avalon-MM register slave: byte-enabled register bank, local hw write port,
// pipelined fixed-latency reads with waitrequest bounding outstanding reads.
module tiger_avalon_slave
    import tiger_avalon_pkg::*;
#(
    parameter int NUM_REGS     = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   avs_address,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [AV_DATA_W-1:0]          avs_writedata,
    input  logic [AV_BE_W-1:0]            avs_byteenable,
    output logic [AV_DATA_W-1:0]          avs_readdata,
    output logic                          avs_waitrequest,
    output logic                          avs_readdatavalid,
    input  logic                          hw_we,
    input  logic [$clog2(NUM_REGS)-1:0]   hw_index,
    input  logic [AV_DATA_W-1:0]          hw_data,
    output logic [AV_DATA_W*NUM_REGS-1:0] reg_out,
    output logic                          addr_err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][AV_DATA_W-1:0] regs_q, regs_d;
    logic [AV_PEND_W-1:0]               pending;
    logic [IDX_W-1:0]                   bus_idx;
    logic                               out_of_range;
    logic                               rd_acc, wr_acc, wr_ok, err_d, ret_next;
    logic [AV_DATA_W-1:0]               rd_snap;
    logic                               unused_addr_lsb;

    assign unused_addr_lsb = ^avs_address[1:0];
    assign bus_idx         = avs_address[2+IDX_W-1:2];
    assign out_of_range    = |avs_address[31:2+IDX_W];

    assign avs_waitrequest = avs_read && (pending == AV_PEND_W'(MAX_PENDING));
    assign rd_acc          = avs_read && !avs_waitrequest;
    assign wr_acc          = avs_write && !avs_waitrequest;
    // A write riding alongside a read is illegal and dropped.
    assign wr_ok           = wr_acc && !avs_read && !out_of_range;
    assign err_d           = (rd_acc && out_of_range) ||
                             (wr_acc && (avs_read || out_of_range));
    assign rd_snap         = out_of_range ? AV_ERR_DATA : regs_q[bus_idx];

    // hw write first, bus write merged over it so enabled lanes win.
    always_comb begin
        regs_d = regs_q;
        if (hw_we) regs_d[hw_index] = hw_data;
        if (wr_ok) regs_d[bus_idx] = be_merge(regs_d[bus_idx], avs_writedata, avs_byteenable);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q   <= '0;
            pending  <= '0;
            addr_err <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pending  <= pending + AV_PEND_W'(rd_acc) - AV_PEND_W'(ret_next);
            addr_err <= err_d;
        end
    end

    assign reg_out = regs_q;

    tiger_avalon_read_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_pipe (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (rd_acc),
        .in_data          (rd_snap),
        .ret_next         (ret_next),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid)
    );

endmodule

// File: tb/tb_tiger_avalon_slave.sv
// Scoreboard bench: instance A (latency 2, 4 pending) and B (latency 3, 1 pending).
module tb_tiger_avalon_slave;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A
    logic [31:0]  a_addr = '0, a_wdata = '0, a_hw_data = '0, a_rdata;
    logic         a_read = 0, a_write = 0, a_hw_we = 0, a_wait, a_rvld, a_err;
    logic [3:0]   a_be = '0, a_hw_idx = '0;
    logic [511:0] a_reg_out;
    // instance B
    logic [31:0]  b_addr = '0, b_wdata = '0, b_hw_data = '0, b_rdata;
    logic         b_read = 0, b_write = 0, b_hw_we = 0, b_wait, b_rvld, b_err;
    logic [3:0]   b_be = '0, b_hw_idx = '0;
    logic [511:0] b_reg_out;

    tiger_avalon_slave #(.NUM_REGS(16), .READ_LATENCY(2), .MAX_PENDING(4)) u_dut_a (
        .clk(clk), .reset(reset), .avs_address(a_addr), .avs_read(a_read),
        .avs_write(a_write), .avs_writedata(a_wdata), .avs_byteenable(a_be),
        .avs_readdata(a_rdata), .avs_waitrequest(a_wait), .avs_readdatavalid(a_rvld),
        .hw_we(a_hw_we), .hw_index(a_hw_idx), .hw_data(a_hw_data),
        .reg_out(a_reg_out), .addr_err(a_err));

    tiger_avalon_slave #(.NUM_REGS(16), .READ_LATENCY(3), .MAX_PENDING(1)) u_dut_b (
        .clk(clk), .reset(reset), .avs_address(b_addr), .avs_read(b_read),
        .avs_write(b_write), .avs_writedata(b_wdata), .avs_byteenable(b_be),
        .avs_readdata(b_rdata), .avs_waitrequest(b_wait), .avs_readdatavalid(b_rvld),
        .hw_we(b_hw_we), .hw_index(b_hw_idx), .hw_data(b_hw_data),
        .reg_out(b_reg_out), .addr_err(b_err));

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference state for both instances
    logic [15:0][31:0] ma = '0, mb = '0;
    logic              erra = 0, errb = 0;
    exp_t              qa[$], qb[$];
    int                b_acc = 0, b_ret = 0, b_last = -1;

    initial forever begin
        logic       oor, racc, wacc;
        logic [3:0] idx;
        exp_t       e;
        @(negedge clk);
        if (reset) begin
            qa.delete(); qb.delete();
            ma = '0; mb = '0; erra = 0; errb = 0; b_last = -1;
        end else begin
            // ---- A ----
            chk("a_reg_out", a_reg_out, ma);
            chk("a_addr_err", a_err, erra);
            if (a_rvld) begin
                if (qa.size() == 0) chk("a_spurious_rvld", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_rdata", a_rdata, e.data);
                    chk("a_latency", cyc - e.cyc, 2);
                end
            end
            oor  = (a_addr[31:6] != 0);
            idx  = a_addr[5:2];
            racc = a_read && !a_wait;
            wacc = a_write && !a_wait;
            if (racc) qa.push_back('{data: (oor ? 32'hDEAD_BEEF : ma[idx]), cyc: cyc});
            erra = (racc && oor) || (wacc && (a_read || oor));
            if (a_hw_we) ma[a_hw_idx] = a_hw_data;
            if (wacc && !a_read && !oor)
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) ma[idx][8*b +: 8] = a_wdata[8*b +: 8];
            // ---- B ----
            chk("b_reg_out", b_reg_out, mb);
            chk("b_addr_err", b_err, errb);
            if (b_rvld) begin
                b_ret++;
                if (qb.size() == 0) chk("b_spurious_rvld", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_rdata", b_rdata, e.data);
                    chk("b_latency", cyc - e.cyc, 3);
                end
            end
            // one read in flight blocks until its return cycle
            chk("b_waitrequest", b_wait, b_read && (qb.size() >= 1));
            if (b_read && !b_wait) begin
                if (b_last >= 0) chk("b_accept_spacing", cyc - b_last, 3);
                b_last = cyc;
                b_acc++;
                qb.push_back('{data: mb[b_addr[5:2]], cyc: cyc});
            end
            if (!b_read) b_last = -1;
            errb = 0;
            if (b_hw_we) mb[b_hw_idx] = b_hw_data;
        end
    end

    task automatic drive_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input logic hwe,
                           input logic [3:0] hidx, input logic [31:0] hd);
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
        a_hw_we = hwe; a_hw_idx = hidx; a_hw_data = hd;
        @(posedge clk); #1;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive_b(input logic rd, input logic [31:0] addr, input logic hwe,
                           input logic [3:0] hidx, input logic [31:0] hd);
        b_read = rd; b_addr = addr; b_hw_we = hwe; b_hw_idx = hidx; b_hw_data = hd;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", a_rdata, 0);
        chk("rst_rvld", a_rvld, 0);
        chk("rst_addr_err", a_err, 0);
        chk("rst_reg_out", a_reg_out, 0);
        @(posedge clk); #1;
        reset = 0;
        idle_a(2);

        // full-word write then read-back
        drive_a(0, 1, 32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
        drive_a(1, 0, 32'h0C, 0, 0, 0, 0, 0);
        idle_a(3);

        // byte-lane merge and BE=0 no-op
        drive_a(0, 0, 0, 0, 0, 1, 5, 32'hAABB_CCDD);
        drive_a(0, 1, 32'h14, 32'h0000_EE00, 4'b0010, 0, 0, 0);
        drive_a(1, 0, 32'h14, 0, 0, 0, 0, 0);
        chk("reg5_be_lane1", a_reg_out[191:160], 32'hAABB_EEDD);
        drive_a(0, 1, 32'h14, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);
        drive_a(1, 0, 32'h14, 0, 0, 0, 0, 0);
        chk("reg5_be_none", a_reg_out[191:160], 32'hAABB_EEDD);
        idle_a(3);

        // out-of-range read and write
        drive_a(1, 0, 32'h100, 0, 0, 0, 0, 0);
        drive_a(0, 1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        idle_a(3);

        // read+write+hw on reg 2: read sees old value, bus write dropped
        drive_a(1, 1, 32'h08, 32'h0000_1111, 4'b0011, 1, 2, 32'h2222_2222);
        idle_a(3);
        // bus write and hw write collide on reg 2
        drive_a(0, 1, 32'h08, 32'h0000_1111, 4'b0011, 1, 2, 32'h2222_2222);
        drive_a(1, 0, 32'h08, 0, 0, 0, 0, 0);
        chk("reg2_merge", a_reg_out[95:64], 32'h2222_1111);
        idle_a(3);

        // back-to-back reads
        for (int i = 0; i < 6; i++) drive_a(1, 0, 32'(i * 4), 0, 0, 0, 0, 0);
        idle_a(4);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ad;
            ad = ($urandom_range(0, 5) == 0) ? (32'h100 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 63));
            drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, $urandom,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom);
        end
        idle_a(4);

        // reset with reads in flight
        drive_a(1, 0, 32'h0C, 0, 0, 0, 0, 0);
        a_addr = 32'h10;
        #1 reset = 1;
        @(posedge clk); #1;
        a_addr = 32'h14;
        @(posedge clk); #1;
        reset = 0;
        a_read = 0;
        chk("rst_mid_rdata", a_rdata, 0);
        chk("rst_mid_rvld", a_rvld, 0);
        idle_a(5);
        drive_a(1, 0, 32'h0C, 0, 0, 0, 0, 0);
        idle_a(4);

        // B: held read with MAX_PENDING=1
        for (int i = 0; i < 4; i++) drive_b(0, 0, 1, 4'(i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 12; i++) drive_b(1, 32'h04, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive_b(1, 32'h08, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive_b(0, 0, 0, 0, 0);

        chk("b_accepts", b_acc, 7);
        chk("b_returns", b_ret, b_acc);
        chk("a_drain", qa.size(), 0);
        chk("b_drain", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
